bm_dag1_sink: RTL

//   Consumer end of the bm_dag1 datapath: accepts the registered {out1,out0}

---
 rtl/bm_dag1_sink.sv | 104 ++++++++++
 1 files changed

// File: rtl/bm_dag1_sink.sv
// Sink for the bm_dag1 result stream: FIFO-buffers {out1,out0} pairs, packs PACK
// of them per output word, and tracks an accepted-entry count and XOR checksum.
`timescale 1ns/1ps
module bm_dag1_sink #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4,
    parameter int PACK  = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            in_data0,
    input  logic                       in_data1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PACK*(BITS+1)-1:0]   out_data,
    output logic [7:0]                 word_count,
    output logic [BITS:0]              checksum
);
    localparam int W  = BITS + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic {COLLECT, PRESENT} state_t;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] slot;
    state_t        state;
    logic [W-1:0]  in_entry;
    logic          push, pop;

    assign in_entry = {in_data1, in_data0};
    // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
    assign in_ready = (count < (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == COLLECT) && (count != '0);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
            checksum   <= '0;
        end else if (push) begin
            word_count <= word_count + 8'd1;
            checksum   <= checksum ^ in_entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= COLLECT;
            slot      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (pop) begin
                        out_data[slot*W +: W] <= mem[rd_ptr];
                        if (slot == SW'(PACK-1)) begin
                            slot      <= '0;
                            state     <= PRESENT;
                            out_valid <= 1'b1;
                        end else begin
                            slot <= slot + SW'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
